// File: rtl/bin_magnitude.sv
// bin_magnitude: alpha-max-beta-min magnitude of each SDFT bin, written to the frequency BRAM.
// Latency: bin k is presented at cycle c and written at c+3; a frame is start + freq_bins + 4 cycles.
// No backpressure: one bin per clock, and start is ignored while busy. Optional peak tracking: BIN_MAGNITUDE_PEAK_DETECT_EN.
module bin_magnitude #(
  parameter int freq_bins  = 16,
  parameter int addr_width = 4,
  parameter int bin_width  = 12,
  parameter int data_width = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [addr_width-1:0]        bin_addr,
  input  logic signed [bin_width-1:0]  bin_real,
  input  logic signed [bin_width-1:0]  bin_imag,
  output logic [addr_width-1:0]        ram_addr,
  output logic [data_width-1:0]        ram_data,
  output logic                         ram_w_en,
  output logic                         busy,
  output logic                         done,
  output logic [addr_width-1:0]        peak_bin,
  output logic [data_width-1:0]        peak_mag
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [addr_width-1:0] last_addr = addr_width'(freq_bins - 1);
  localparam int shift = bin_width - data_width;

  logic [1:0]            state;
  // Read-return stage: the address whose data arrives from the bin memories this cycle
  logic                  rd_vld;
  logic [addr_width-1:0] rd_addr;
  // Stage A: absolute values
  logic                  a_vld;
  logic [addr_width-1:0] a_addr;
  logic [bin_width-1:0]  a_abs_re;
  logic [bin_width-1:0]  a_abs_im;
  // Combinational helpers
  logic [bin_width-1:0]  abs_re;
  logic [bin_width-1:0]  abs_im;
  logic [bin_width-1:0]  mag_max;
  logic [bin_width-1:0]  mag_min;
  logic [bin_width-1:0]  mag;
  logic                  last_wr;

  assign last_wr = ram_w_en && (ram_addr == last_addr);
  assign busy    = (state == S_RUN) || (state == S_DRAIN);
  assign done    = (state == S_DONE);

  // Frame sequencer: walk the bin addresses, then wait for the final write to leave the pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bin_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            bin_addr <= '0;
          end
        end
        S_RUN: begin
          if (bin_addr == last_addr) state <= S_DRAIN;
          else                       bin_addr <= bin_addr + 1'b1;
        end
        S_DRAIN: begin
          if (last_wr) state <= S_DONE;
        end
        default: begin
          state    <= S_IDLE;
          bin_addr <= '0;
        end
      endcase
    end
  end

  // Absolute value as unsigned: the most negative input maps to 2^(bin_width-1) without overflow
  always_comb begin
    abs_re = bin_real[bin_width-1] ? $unsigned(-bin_real) : $unsigned(bin_real);
    abs_im = bin_imag[bin_width-1] ? $unsigned(-bin_imag) : $unsigned(bin_imag);
  end

  // max + 0.375*min; the sum stays below 2^bin_width so no extra bit is needed
  always_comb begin
    mag_max = (a_abs_re >= a_abs_im) ? a_abs_re : a_abs_im;
    mag_min = (a_abs_re >= a_abs_im) ? a_abs_im : a_abs_re;
    mag     = mag_max + (mag_min >> 2) + (mag_min >> 3);
  end

  // Three-stage pipeline: read return, |re|/|im|, magnitude and BRAM write
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld   <= 1'b0;
      rd_addr  <= '0;
      a_vld    <= 1'b0;
      a_addr   <= '0;
      a_abs_re <= '0;
      a_abs_im <= '0;
      ram_w_en <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      rd_vld   <= (state == S_RUN);
      rd_addr  <= bin_addr;
      a_vld    <= rd_vld;
      a_addr   <= rd_addr;
      a_abs_re <= abs_re;
      a_abs_im <= abs_im;
      ram_w_en <= a_vld;
      ram_addr <= a_addr;
      ram_data <= a_vld ? data_width'(mag >> shift) : '0;
    end
  end

`ifdef BIN_MAGNITUDE_PEAK_DETECT_EN
  logic [data_width-1:0] trk_mag;
  logic [addr_width-1:0] trk_bin;
  logic                  wr_gt;

  // Strict compare keeps the earliest (lowest) address on ties
  assign wr_gt = ram_w_en && (ram_data > trk_mag);

  // Track the running peak; publish it on the edge that enters the done cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_mag  <= '0;
      trk_bin  <= '0;
      peak_mag <= '0;
      peak_bin <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        trk_mag <= '0;
        trk_bin <= '0;
      end else if (wr_gt) begin
        trk_mag <= ram_data;
        trk_bin <= ram_addr;
      end
      if ((state == S_DRAIN) && last_wr) begin
        peak_mag <= wr_gt ? ram_data : trk_mag;
        peak_bin <= wr_gt ? ram_addr : trk_bin;
      end
    end
  end
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_bin_magnitude.sv
// Testbench for bin_magnitude: directed table frame, re-pulsed start, back-to-back frames,
// mid-frame reset, peak tie case and random frames against a behavioural model.
// Bin memories are modelled as a registered read of local arrays.
module tb_bin_magnitude;

  localparam int NB = 16;
  localparam int AW = 4;
  localparam int BW = 12;
  localparam int DW = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [AW-1:0]         bin_addr;
  logic signed [BW-1:0]  bin_real;
  logic signed [BW-1:0]  bin_imag;
  logic [AW-1:0]         ram_addr;
  logic [DW-1:0]         ram_data;
  logic                  ram_w_en;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         peak_bin;
  logic [DW-1:0]         peak_mag;

  bin_magnitude #(.freq_bins(NB), .addr_width(AW), .bin_width(BW), .data_width(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_addr(bin_addr),
    .bin_real(bin_real), .bin_imag(bin_imag), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_w_en(ram_w_en), .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  always #5 clk = ~clk;

  int mem_re [NB];
  int mem_im [NB];

  // Upstream bin memories: registered read, data valid one cycle after the address
  always @(posedge clk) begin
    bin_real <= BW'(mem_re[bin_addr]);
    bin_imag <= BW'(mem_im[bin_addr]);
  end

  typedef struct {
    int re;
    int im;
    int mag;
  } vec_t;

  vec_t tbl [NB];
  int   exp_mag [NB];
  int   fp_bin, fp_mag;        // expected peak of the frame being run
  int   hold_bin, hold_mag;    // expected values currently on peak outputs
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic int ref_mag(input int re, input int im);
    int a, b, hi, lo;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    hi = (a > b) ? a : b;
    lo = (a > b) ? b : a;
    return (hi + lo / 4 + lo / 8) / (1 << (BW - DW));
  endfunction

  // Expected magnitudes and peak from the current memory contents
  task automatic model_frame();
    for (int k = 0; k < NB; k++) exp_mag[k] = ref_mag(mem_re[k], mem_im[k]);
    fp_bin = 0;
    fp_mag = exp_mag[0];
    for (int k = 1; k < NB; k++)
      if (exp_mag[k] > fp_mag) begin
        fp_mag = exp_mag[k];
        fp_bin = k;
      end
  endtask

  task automatic load_directed();
    for (int k = 0; k < NB; k++) begin
      mem_re[k]  = tbl[k].re;
      mem_im[k]  = tbl[k].im;
      exp_mag[k] = tbl[k].mag;
    end
    fp_bin = 2;
    fp_mag = 176;
  endtask

  task automatic load_random(input int lim);
    for (int k = 0; k < NB; k++) begin
      mem_re[k] = $signed($urandom_range(2 * lim, 0)) - lim;
      mem_im[k] = $signed($urandom_range(2 * lim, 0)) - lim;
    end
  endtask

  task automatic chk_peak();
    chk("peak_bin", int'(peak_bin), hold_bin);
    chk("peak_mag", int'(peak_mag), hold_mag);
  endtask

  // Start a frame in cycle rel=0 and check every cycle through rel=20.
  // pa/pb: extra start pulses; rst_at: cycle in which reset is driven high (-1 none).
  task automatic run_frame(input int pa, input int pb, input int rst_at);
    bit aborted;
    aborted = 0;
    @(negedge clk);
    start = 1'b1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge clk);
      if (rst_at > 0 && rel == rst_at + 1) begin
        aborted  = 1;
        hold_bin = 0;
        hold_mag = 0;
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_data", int'(ram_data), 0);
        chk("rst_bin_addr", int'(bin_addr), 0);
      end
      if (aborted) begin
        chk("abort_w_en", int'(ram_w_en), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
      end else begin
        chk("w_en", int'(ram_w_en), (rel >= 4 && rel <= 19) ? 1 : 0);
        if (rel >= 4 && rel <= 19) begin
          chk("ram_addr", int'(ram_addr), rel - 4);
          chk("ram_data", int'(ram_data), exp_mag[rel - 4]);
        end
        chk("busy", int'(busy), (rel <= 19) ? 1 : 0);
        chk("done", int'(done), (rel == 20) ? 1 : 0);
        if (rel == 20) begin
`ifdef BIN_MAGNITUDE_PEAK_DETECT_EN
          hold_bin = fp_bin;
          hold_mag = fp_mag;
`endif
        end
      end
      chk_peak();
      start = (rel == pa || rel == pb) ? 1'b1 : 1'b0;
      reset = (rel == rst_at) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("idle_w_en", int'(ram_w_en), 0);
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk_peak();
    end
  endtask

  initial begin
    for (int k = 0; k < NB; k++) begin
      tbl[k]    = '{re: 0, im: 0, mag: 0};
      mem_re[k] = 0;
      mem_im[k] = 0;
    end
    tbl[0] = '{re: 100,   im: -40,   mag: 7};
    tbl[1] = '{re: -2048, im: 0,     mag: 128};
    tbl[2] = '{re: -2048, im: -2048, mag: 176};
    tbl[3] = '{re: 2047,  im: 2047,  mag: 175};
    hold_bin = 0;
    hold_mag = 0;

    // Reset held three cycles with start high: everything stays at zero
    reset = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_w_en", int'(ram_w_en), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_bin_addr", int'(bin_addr), 0);
      chk("reset_ram_addr", int'(ram_addr), 0);
      chk("reset_ram_data", int'(ram_data), 0);
      chk_peak();
    end
    reset = 1'b0;
    start = 1'b0;
    idle_check(2);

    // Directed frame from the table
    load_directed();
    run_frame(-1, -1, -1);
    idle_check(2);

    // Start re-pulsed mid-frame and in the done cycle: both ignored
    run_frame(5, 20, -1);
    idle_check(3);

    // Back-to-back frames: second start one cycle after done
    run_frame(-1, -1, -1);
    load_random(2048);
    model_frame();
    run_frame(-1, -1, -1);
    idle_check(2);

    // Reset in cycle T+8 aborts; the next frame is complete and correct
    load_directed();
    run_frame(-1, -1, 8);
    idle_check(1);
    run_frame(-1, -1, -1);
    idle_check(2);

    // Tie: bins 5 and 9 both at 128, all others well below
    load_random(700);
    mem_re[5] = 0;     mem_im[5] = -2048;
    mem_re[9] = -2048; mem_im[9] = 0;
    model_frame();
    run_frame(-1, -1, -1);
    idle_check(2);

    // Random full-range frames
    for (int f = 0; f < 4; f++) begin
      load_random(2048);
      if (f == 1) begin
        mem_re[7] = -2048;
        mem_im[7] = -2048;
      end
      model_frame();
      run_frame(-1, -1, -1);
      idle_check(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_magnitude.md
Name: bin_magnitude

Overview:
- Downstream of the sliding-DFT core; consumes the complex frequency bins after each processed sample.
- Computes an integer magnitude estimate per bin using alpha-max-beta-min.
- Writes the result into the frequency BRAM consumed by the display/readout path.
- Streams all bins through a 3-stage pipeline, one bin per clock.

Parameters:
- freq_bins, 16, number of bins per frame (power of two).
- addr_width, 4, log2(freq_bins).
- bin_width, 12, width of signed real/imag bin values.
- data_width, 8, width of the magnitude word written to BRAM (data_width <= bin_width).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the SDFT: bins are stable for the frame.
- bin_addr  out  addr_width  bin read address into the SDFT bin memories.
- bin_real  in  bin_width  signed real part; registered read, valid one cycle after bin_addr.
- bin_imag  in  bin_width  signed imaginary part; same timing as bin_real.
- ram_addr  out  addr_width  BRAM write address.
- ram_data  out  data_width  magnitude to write.
- ram_w_en  out  1  BRAM write strobe.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write.
- peak_bin  out  addr_width  see Optional Feature.
- peak_mag  out  data_width  see Optional Feature.

Behaviour:
- Reset: all outputs are 0 on the first clock edge with reset high; state goes to IDLE; pipeline valids are cleared.
- Reset mid-frame aborts with no further writes and no done pulse.
- States:
  - IDLE: start sampled high at edge T moves to RUN; bin_addr=0 during cycle T+1.
  - RUN: bin_addr increments each cycle, covering 0..freq_bins-1. After presenting freq_bins-1, go to DRAIN.
  - DRAIN: wait until the pipeline has issued its final write, then go to DONE.
  - DONE: done=1 for one cycle, busy=0 in that cycle, return to IDLE.
- Pipeline, for address k presented in cycle c:
  - Cycle c+1: bin data arrives; stage A registers |re| and |im| as unsigned bin_width values. |-2^(bin_width-1)| = 2^(bin_width-1); no overflow.
  - Stage B registers mag = max + (min>>2) + (min>>3), unsigned bin_width bits. This never overflows, since 1.375*2^(bin_width-1) < 2^bin_width.
  - Cycle c+3: ram_w_en=1, ram_addr=k, ram_data = mag >> (bin_width - data_width) (truncation, no rounding).
- Frame timing: start at edge T gives writes in cycles T+4..T+freq_bins+3, done in cycle T+freq_bins+4.
- Each bin is written exactly once per frame, in ascending address order, on consecutive cycles.
- start while busy (including the DONE cycle) is ignored; no queuing.
- start in the same cycle as reset is ignored.
- ram_w_en is never high outside the write window.

Optional Feature:
- Macro: BIN_MAGNITUDE_PEAK_DETECT_EN.
- When defined:
  - Track the maximum ram_data written in the frame and its ram_addr.
  - Use a strict greater-than compare, so the lowest index wins ties.
  - peak_bin/peak_mag update only in the done cycle and hold until the next done or reset.
  - Internal trackers clear on accepted start.
- When undefined: peak_bin and peak_mag are constant 0, and no tracking logic is present.

Test Plan:
- Reset: hold reset 3 cycles with start high -> all outputs 0, no writes, busy=0.
- Single frame, bin_width=12, data_width=8. Bins: bin0 (100,-40), bin1 (-2048,0), bin2 (-2048,-2048), bin3 (2047,2047), others (0,0).
  - Expected ram_data: 7, 128, 176, 175, then 0 for the rest.
  - Writes occur in cycles T+4..T+19; done in cycle T+20.
- start re-pulsed at T+5 and at the done cycle -> ignored: exactly 16 writes, one done pulse.
- Back-to-back frames: start one cycle after done -> second frame timing identical to the first; addresses 0..15 again.
- Reset asserted at T+8 -> ram_w_en=0 from the next cycle, no done pulse. A following start runs a complete, correct frame.
- With BIN_MAGNITUDE_PEAK_DETECT_EN and the frame above -> peak_bin=2, peak_mag=176 at done.
  - Tie case: bins 5 and 9 both 128, all others lower -> peak_bin=5.
  - Without the macro -> peak outputs remain 0.
